fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Single-port framebuffer arbiter and double-buffer controller for the line-drawing video path. It shares one synchronous framebuffer RAM between the scanout fetch, which has hard real-time priority, and two drawing requesters: the line rasterizer and the clear engine. It selects front and back buffers through the top address bit and performs buffer swaps only at the start of vertical blank, so partially drawn frames are never displayed.

## Interface
- ADDR_W, 16: per-buffer word address width; RAM address width is ADDR_W+1.
- DATA_W, 8: pixel word width.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- vblank  in  1  vertical blank from video timing
- scan_req  in  1  scanout read request, single-cycle strobe
- scan_addr  in  ADDR_W  scanout pixel address
- scan_rvalid  out  1  scanout read data valid
- scan_rdata  out  DATA_W  scanout read data
- dN_req  in  1  draw requester N (N=0,1) request, held until granted
- dN_we  in  1  1 = write, 0 = read
- dN_addr  in  ADDR_W  back-buffer address
- dN_wdata  in  DATA_W  write data
- dN_gnt  out  1  request accepted this cycle (combinational)
- dN_rvalid  out  1  read data valid
- dN_rdata  out  DATA_W  read data
- swap_req  in  1  pulse; request buffer swap at next vblank rise
- swap_pending  out  1  a swap is armed
- swap_done  out  1  one-cycle pulse when the swap occurs
- front_buf  out  1  buffer currently scanned out
- mem_addr  out  ADDR_W+1  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the command

## Operation
- Priority: scan_req always wins. A scan cycle grants no draw requester. Scan reads use address {front_buf, scan_addr}.
- Draw arbitration happens only in cycles without scan_req.
  - If one draw requester is active, it is granted.
  - If both are active, the one not granted most recently wins.
  - The round-robin pointer updates only on a draw grant and resets to favour d0.
- Draw accesses use address {~front_buf, dN_addr}. The buffer bit is captured at acceptance; a later swap does not retarget an in-flight access.
- Writes produce no rvalid. Reads return data on that requester's rvalid/rdata only.
- A 2-stage source tag pipeline (NONE/SCAN/D0/D1) routes mem_rdata to the correct requester. Non-selected rdata outputs are don't-care.
- Swap control:
  - swap_req sets swap_pending. A repeat swap_req while pending is a no-op.
  - On the vblank 0→1 edge with swap_pending set: toggle front_buf, clear swap_pending, and pulse swap_done.
  - If swap_req arrives in the same cycle as the vblank edge, the swap is taken on that edge.
  - A vblank edge with nothing pending does nothing.
- No scan request in a cycle means that cycle is free for draw traffic. Draw requesters may be starved during dense active-video fetch; this is accepted.

## Timing
- Cycle N: request sampled, gnt asserted combinationally.
- Cycle N+1: mem_* show the command.
- Cycle N+2: mem_rdata is valid and is presented combinationally with the registered rvalid.
- Read latency from acceptance is 2 cycles. Throughput is one access per cycle.
- Reset values:
  - All gnt, rvalid and swap_done = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - front_buf = 0, swap_pending = 0.
  - Tag pipeline = NONE, vblank edge register = 0.
- Reset mid-operation clears the tag pipeline. No rvalid is issued in the cycles after reset for commands accepted before it.
- The swap happens in the cycle following the sampled vblank rise; front_buf changes in the same cycle as swap_done.

## Structure
- Package fb_pkg holds the src_t enum (SRC_NONE, SRC_SCAN, SRC_D0, SRC_D1) and the ADDR_W/DATA_W defaults.
- Sub-module fb_rr_arb: a 2-way round-robin arbiter with its pointer register and combinational grants. The top level handles scan override, address muxing, the tag pipeline and swap control.

## Test plan
- After reset, d0 writes addr 0x0010 = 0x5A: mem_addr = 0x10010 (back buffer 1) and mem_we = 1 one cycle after d0_gnt. A later d0 read of 0x0010 gives d0_rvalid with 0x5A two cycles after gnt.
- scan_req, d0_req and d1_req all asserted together: scan is served and both dN_gnt = 0. With scan idle for 4 cycles, grants alternate d0, d1, d0, d1.
- scan_req strobes every other cycle with d1 read requests held: scan_rvalid and d1_rvalid never coincide with a wrong tag, and each returns its own address's data.
- swap_req during active video: swap_pending = 1 and front_buf stays 0. On the vblank rise, front_buf = 1 and swap_done pulses once. A second vblank without swap_req leaves front_buf = 1.
- swap_req in the same cycle as the vblank rise: the swap happens on that edge. A d0 write accepted one cycle before the edge still targets the old back buffer (bit 1).
- Reset asserted one cycle after a d0 read is granted: no d0_rvalid afterwards, and all outputs hold their reset values.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer arbiter.
//   src_t      : tag identifying who owns an in-flight RAM read
//   ADDR_W_DEF : per-buffer word address width
//   DATA_W_DEF : pixel word width
package fb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SCAN = 2'd1,
    SRC_D0   = 2'd2,
    SRC_D1   = 2'd3
  } src_t;
endpackage

// File: rtl/fb_rr_arb.sv
// Two-way round-robin arbiter for the draw requesters.
//   clk, reset : clock, synchronous active-high reset
//   en         : arbitration allowed this cycle (no scan, not in reset)
//   req0/req1  : draw requests
//   gnt0/gnt1  : combinational grants, at most one high
module fb_rr_arb
  import fb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // fav1 = 1 means requester 1 wins a tie; reset favours requester 0.
  logic fav1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = ~fav1;
        gnt1 = fav1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fav1 <= 1'b0;
    end else if (gnt0) begin
      fav1 <= 1'b1;
    end else if (gnt1) begin
      fav1 <= 1'b0;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter with double-buffer swap control.
// Scanout reads the front buffer with absolute priority; two draw
// requesters share the remaining cycles round-robin and target the
// back buffer. Buffer swaps are deferred to the next vblank rise.
//   clk, reset           : clock, synchronous active-high reset
//   vblank               : vertical blank from video timing
//   scan_*               : scanout read port (strobe request, rvalid/rdata)
//   d0_*, d1_*           : draw ports (held request, comb gnt, rvalid/rdata)
//   swap_req             : arm a buffer swap
//   swap_pending/done    : swap armed / one-cycle swap pulse
//   front_buf            : buffer currently scanned out
//   mem_*                : registered RAM command, mem_rdata one cycle later
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_rvalid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              d0_req,
  input  logic              d0_we,
  input  logic [ADDR_W-1:0] d0_addr,
  input  logic [DATA_W-1:0] d0_wdata,
  output logic              d0_gnt,
  output logic              d0_rvalid,
  output logic [DATA_W-1:0] d0_rdata,
  input  logic              d1_req,
  input  logic              d1_we,
  input  logic [ADDR_W-1:0] d1_addr,
  input  logic [DATA_W-1:0] d1_wdata,
  output logic              d1_gnt,
  output logic              d1_rvalid,
  output logic [DATA_W-1:0] d1_rdata,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_buf,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  src_t              tag1, tag2;
  src_t              cmd_src;
  logic [ADDR_W:0]   cmd_addr;
  logic              cmd_we;
  logic [DATA_W-1:0] cmd_wdata;
  logic              vblank_q;
  logic              vblank_rise;

  fb_rr_arb u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (~scan_req & ~reset),
    .req0  (d0_req),
    .req1  (d1_req),
    .gnt0  (d0_gnt),
    .gnt1  (d1_gnt)
  );

  // Buffer bit is taken from front_buf at acceptance, so a swap on the
  // following edge cannot retarget a command already registered.
  always_comb begin
    cmd_src   = SRC_NONE;
    cmd_addr  = mem_addr;
    cmd_we    = 1'b0;
    cmd_wdata = mem_wdata;
    if (!reset) begin
      if (scan_req) begin
        cmd_src  = SRC_SCAN;
        cmd_addr = {front_buf, scan_addr};
      end else if (d0_gnt) begin
        cmd_src   = d0_we ? SRC_NONE : SRC_D0;
        cmd_addr  = {~front_buf, d0_addr};
        cmd_we    = d0_we;
        cmd_wdata = d0_wdata;
      end else if (d1_gnt) begin
        cmd_src   = d1_we ? SRC_NONE : SRC_D1;
        cmd_addr  = {~front_buf, d1_addr};
        cmd_we    = d1_we;
        cmd_wdata = d1_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      tag1      <= SRC_NONE;
      tag2      <= SRC_NONE;
    end else begin
      mem_addr  <= cmd_addr;
      mem_we    <= cmd_we;
      mem_wdata <= cmd_wdata;
      tag1      <= cmd_src;
      tag2      <= tag1;
    end
  end

  // tag2 lines up with the cycle in which mem_rdata is valid.
  assign scan_rvalid = (tag2 == SRC_SCAN);
  assign d0_rvalid   = (tag2 == SRC_D0);
  assign d1_rvalid   = (tag2 == SRC_D1);
  assign scan_rdata  = mem_rdata;
  assign d0_rdata    = mem_rdata;
  assign d1_rdata    = mem_rdata;

  assign vblank_rise = vblank & ~vblank_q;

  // A swap_req coincident with the vblank rise is folded into that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q     <= 1'b0;
      front_buf    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      vblank_q  <= vblank;
      swap_done <= 1'b0;
      if (vblank_rise && (swap_pending || swap_req)) begin
        front_buf    <= ~front_buf;
        swap_pending <= 1'b0;
        swap_done    <= 1'b1;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RAMSZ = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          reset, vblank, scan_req, swap_req;
  logic [AW-1:0] scan_addr, d0_addr, d1_addr;
  logic          d0_req, d0_we, d1_req, d1_we;
  logic [DW-1:0] d0_wdata, d1_wdata;
  logic          scan_rvalid, d0_gnt, d0_rvalid, d1_gnt, d1_rvalid;
  logic [DW-1:0] scan_rdata, d0_rdata, d1_rdata;
  logic          swap_pending, swap_done, front_buf;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .d0_req(d0_req), .d0_we(d0_we), .d0_addr(d0_addr), .d0_wdata(d0_wdata),
    .d0_gnt(d0_gnt), .d0_rvalid(d0_rvalid), .d0_rdata(d0_rdata),
    .d1_req(d1_req), .d1_we(d1_we), .d1_addr(d1_addr), .d1_wdata(d1_wdata),
    .d1_gnt(d1_gnt), .d1_rvalid(d1_rvalid), .d1_rdata(d1_rdata),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
    .front_buf(front_buf), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM.
  logic [DW-1:0] ram [0:RAMSZ-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model state: shadow memory, swap state, tie-break owner.
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  typedef struct { int due; logic [AW:0] addr; logic we; logic [DW-1:0] wdata; } cmd_t;
  rd_t  q_scan[$], q_d0[$], q_d1[$];
  cmd_t q_cmd[$];
  logic [DW-1:0] sh [0:RAMSZ-1];
  logic m_fav1, m_front, m_pend, m_done, m_vbq, m_valid = 1'b0;
  logic lg0 = 1'b0, lg1 = 1'b0;
  logic mon_en = 1'b0;

  // Staged inputs, applied just after each rising edge.
  logic          n_reset, n_vblank, n_scan_req, n_swap_req;
  logic [AW-1:0] n_scan_addr, n_d0_addr, n_d1_addr;
  logic          n_d0_req, n_d0_we, n_d1_req, n_d1_we;
  logic [DW-1:0] n_d0_wdata, n_d1_wdata;

  task automatic tick();
    logic e0, e1, rise;
    logic [AW:0] a;
    cmd_t c;
    rd_t  r;
    @(posedge clk);
    #1;
    reset = n_reset; vblank = n_vblank; scan_req = n_scan_req; scan_addr = n_scan_addr;
    swap_req = n_swap_req;
    d0_req = n_d0_req; d0_we = n_d0_we; d0_addr = n_d0_addr; d0_wdata = n_d0_wdata;
    d1_req = n_d1_req; d1_we = n_d1_we; d1_addr = n_d1_addr; d1_wdata = n_d1_wdata;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (!reset && !scan_req) begin
      if (d0_req && d1_req) begin e0 = !m_fav1; e1 = m_fav1; end
      else begin e0 = d0_req; e1 = d1_req; end
    end
    chk("d0_gnt", d0_gnt, e0);
    chk("d1_gnt", d1_gnt, e1);
    lg0 = d0_gnt; lg1 = d1_gnt;
    if (m_valid) begin
      chk("front_buf", front_buf, m_front);
      chk("swap_pending", swap_pending, m_pend);
      chk("swap_done", swap_done, m_done);
    end
    if (reset) begin
      m_fav1 = 0; m_front = 0; m_pend = 0; m_done = 0; m_vbq = 0; m_valid = 1;
      for (int i = q_scan.size() - 1; i >= 0; i--) if (q_scan[i].due > cyc) q_scan.delete(i);
      for (int i = q_d0.size() - 1; i >= 0; i--) if (q_d0[i].due > cyc) q_d0.delete(i);
      for (int i = q_d1.size() - 1; i >= 0; i--) if (q_d1[i].due > cyc) q_d1.delete(i);
    end else begin
      if (scan_req) begin
        a = {m_front, scan_addr};
        c.due = cyc + 1; c.addr = a; c.we = 0; c.wdata = '0; q_cmd.push_back(c);
        r.due = cyc + 2; r.data = sh[a]; q_scan.push_back(r);
      end else if (e0 || e1) begin
        a = {~m_front, e0 ? d0_addr : d1_addr};
        c.due = cyc + 1; c.addr = a;
        c.we = e0 ? d0_we : d1_we;
        c.wdata = e0 ? d0_wdata : d1_wdata;
        q_cmd.push_back(c);
        if (c.we) sh[a] = c.wdata;
        else begin
          r.due = cyc + 2; r.data = sh[a];
          if (e0) q_d0.push_back(r); else q_d1.push_back(r);
        end
        m_fav1 = e0;
      end
      rise = vblank && !m_vbq;
      m_vbq = vblank;
      m_done = 0;
      if (rise && (m_pend || swap_req)) begin
        m_front = ~m_front; m_pend = 0; m_done = 1;
      end else if (swap_req) m_pend = 1;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    rd_t  r;
    cmd_t c;
    if (mon_en) begin
      if (scan_rvalid) begin
        if (q_scan.size() == 0) chk("scan_rvalid_spurious", 1, 0);
        else begin r = q_scan.pop_front(); chk("scan_lat", cyc, r.due); chk("scan_rdata", scan_rdata, r.data); end
      end else if (q_scan.size() > 0 && q_scan[0].due <= cyc) begin
        chk("scan_rvalid_missing", 0, 1); void'(q_scan.pop_front());
      end
      if (d0_rvalid) begin
        if (q_d0.size() == 0) chk("d0_rvalid_spurious", 1, 0);
        else begin r = q_d0.pop_front(); chk("d0_lat", cyc, r.due); chk("d0_rdata", d0_rdata, r.data); end
      end else if (q_d0.size() > 0 && q_d0[0].due <= cyc) begin
        chk("d0_rvalid_missing", 0, 1); void'(q_d0.pop_front());
      end
      if (d1_rvalid) begin
        if (q_d1.size() == 0) chk("d1_rvalid_spurious", 1, 0);
        else begin r = q_d1.pop_front(); chk("d1_lat", cyc, r.due); chk("d1_rdata", d1_rdata, r.data); end
      end else if (q_d1.size() > 0 && q_d1[0].due <= cyc) begin
        chk("d1_rvalid_missing", 0, 1); void'(q_d1.pop_front());
      end
      if (q_cmd.size() > 0 && q_cmd[0].due <= cyc) begin
        c = q_cmd.pop_front();
        chk("mem_we", mem_we, c.we);
        chk("mem_addr", mem_addr, c.addr);
        if (c.we) chk("mem_wdata", mem_wdata, c.wdata);
      end else chk("mem_we_idle", mem_we, 0);
    end
  end

  task automatic do_reset();
    n_reset = 1; tick(); n_reset = 0;
  endtask

  initial begin
    for (int i = 0; i < RAMSZ; i++) begin ram[i] = '0; sh[i] = '0; end
    n_reset = 1; n_vblank = 0; n_scan_req = 0; n_swap_req = 0; n_scan_addr = '0;
    n_d0_req = 0; n_d0_we = 0; n_d0_addr = '0; n_d0_wdata = '0;
    n_d1_req = 0; n_d1_we = 0; n_d1_addr = '0; n_d1_wdata = '0;
    repeat (3) tick();
    n_reset = 0;
    mon_en = 1;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", {scan_rvalid, d0_rvalid, d1_rvalid}, 0);

    // d0 write 0x0010 = 0x5A, then read it back.
    n_d0_req = 1; n_d0_we = 1; n_d0_addr = 16'h0010; n_d0_wdata = 8'h5A; tick();
    chk("t1_gnt", d0_gnt, 1);
    n_d0_req = 0; tick();
    chk("t1_mem_addr", mem_addr, 17'h10010);
    chk("t1_mem_we", mem_we, 1);
    n_d0_req = 1; n_d0_we = 0; tick();
    n_d0_req = 0; tick(); tick();
    chk("t1_rvalid", d0_rvalid, 1);
    chk("t1_rdata", d0_rdata, 8'h5A);

    // Scan beats both draws, then round-robin from a fresh pointer.
    do_reset();
    n_scan_req = 1; n_scan_addr = 16'h0005;
    n_d0_req = 1; n_d0_we = 0; n_d0_addr = 16'h0010;
    n_d1_req = 1; n_d1_we = 0; n_d1_addr = 16'h0011;
    tick();
    chk("t2_scan_block", {d0_gnt, d1_gnt}, 2'b00);
    n_scan_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_rr_d0", d0_gnt, (i % 2 == 0));
      chk("t2_rr_d1", d1_gnt, (i % 2 == 1));
    end
    n_d0_req = 0; n_d1_req = 0;

    // Random traffic with swaps, vblank and occasional resets.
    for (int i = 0; i < 800; i++) begin
      n_reset = ($urandom_range(0, 199) == 0);
      n_scan_req = ($urandom_range(0, 2) == 0);
      n_scan_addr = 16'($urandom_range(0, 15));
      if (!n_d0_req || lg0) begin
        n_d0_req = $urandom_range(0, 1); n_d0_we = $urandom_range(0, 1);
        n_d0_addr = 16'($urandom_range(0, 15)); n_d0_wdata = 8'($urandom);
      end
      if (!n_d1_req || lg1) begin
        n_d1_req = $urandom_range(0, 1); n_d1_we = $urandom_range(0, 1);
        n_d1_addr = 16'($urandom_range(0, 15)); n_d1_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0) n_vblank = ~n_vblank;
      n_swap_req = ($urandom_range(0, 29) == 0);
      tick();
    end
    n_reset = 0; n_swap_req = 0; n_d0_req = 0; n_d1_req = 0;

    // Scan every other cycle with d1 reads held.
    for (int i = 0; i < 24; i++) begin
      n_scan_req = (i % 2 == 0);
      n_scan_addr = 16'($urandom_range(0, 15));
      if (!n_d1_req || lg1) begin
        n_d1_req = 1; n_d1_we = 0; n_d1_addr = 16'($urandom_range(0, 15));
      end
      tick();
    end
    n_scan_req = 0; n_d1_req = 0;

    // Swap during active video, then vblank rises.
    n_vblank = 0; do_reset();
    n_swap_req = 1; tick();
    n_swap_req = 0; tick();
    chk("t4_pending", swap_pending, 1);
    chk("t4_front_hold", front_buf, 0);
    n_vblank = 1; tick(); tick();
    chk("t4_front", front_buf, 1);
    chk("t4_done", swap_done, 1);
    tick();
    chk("t4_done_once", swap_done, 0);
    n_vblank = 0; tick(); tick();
    n_vblank = 1; tick(); tick();
    chk("t4_no_swap", front_buf, 1);
    chk("t4_no_done", swap_done, 0);

    // swap_req on the vblank rise, with a write one cycle earlier.
    n_vblank = 0; do_reset(); tick();
    n_d0_req = 1; n_d0_we = 1; n_d0_addr = 16'h0020; n_d0_wdata = 8'h33; tick();
    n_d0_req = 0; n_vblank = 1; n_swap_req = 1; tick();
    chk("t5_mem_addr", mem_addr, 17'h10020);
    n_swap_req = 0; tick();
    chk("t5_front", front_buf, 1);
    chk("t5_done", swap_done, 1);

    // Reset one cycle after a d0 read is granted.
    n_d0_req = 1; n_d0_we = 0; n_d0_addr = 16'h0020; tick();
    chk("t6_gnt", d0_gnt, 1);
    n_d0_req = 0; n_reset = 1; tick();
    n_reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_rvalid", d0_rvalid, 0);
      chk("t6_mem_we", mem_we, 0);
      chk("t6_mem_addr", mem_addr, 0);
      chk("t6_mem_wdata", mem_wdata, 0);
      chk("t6_front", front_buf, 0);
      chk("t6_pending", swap_pending, 0);
    end

    repeat (4) tick();
    chk("queues_drained", q_scan.size() + q_d0.size() + q_d1.size() + q_cmd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
